transmit_dac: RTL and testbench
===============================

TRANSMIT_DAC -- requirements
Module: transmit_dac

Interface
REQ-001 SHALL have parameter DATA_W, default 12, DAC data word width.
REQ-002 SHALL have parameter CTRL_W, default 4, control prefix width; frame length FRAME_W = CTRL_W + DATA_W (16 by default).
REQ-003 SHALL have parameter CTRL, default 4'b0000, control prefix sent ahead of the data.
REQ-004 SHALL have parameter DIV, default 2, system cycles per dac_sclk half-period; legal range 1..255.
REQ-005 SHALL have port sclk  input  1  system clock; all state on rising edge; one clock only.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port tx_start  input  1  request to send din (sampled on sclk rising edge).
REQ-008 SHALL have port din  input  DATA_W  word to transmit, captured in the cycle tx_start is accepted.
REQ-009 SHALL have port dac_sclk  output  1  serial clock to DAC, idle high.
REQ-010 SHALL have port sdata  output  1  serial data, MSB first.
REQ-011 SHALL have port cs  output  1  active-low chip select/sync.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port tx_done_tick  output  1  one-cycle pulse at end of frame.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, SHIFT, DONE.
REQ-015 In IDLE, tx_start=1 SHALL load shift register with {CTRL, din} and go to SETUP next cycle.
REQ-016 SETUP SHALL last DIV cycles: cs=0, dac_sclk=1, sdata=frame bit FRAME_W-1; then go to SHIFT.
REQ-017 SHIFT SHALL toggle dac_sclk every DIV cycles, starting with a fall; on each rise, shift the register left by one so sdata presents the next bit.
REQ-018 The DAC samples on dac_sclk falling edges; sdata SHALL be stable for DIV cycles either side of each fall.
REQ-019 After the FRAME_W-th fall and its DIV-cycle low phase, SHALL go to DONE; cs is low for exactly 32*DIV cycles per default frame.
REQ-020 DONE SHALL last one cycle: cs=1, dac_sclk=1, tx_done_tick=1; then go to IDLE.
REQ-021 busy SHALL be 1 in SETUP, SHIFT and DONE, and 0 in IDLE.
REQ-022 A bit counter (width ceil(log2(FRAME_W+1))) and a half-period counter (8 bits) SHALL both clear on every state entry; neither may wrap within a frame.
REQ-023 In IDLE, sdata SHALL be 0, cs 1 and dac_sclk 1.
REQ-024 Without TX_DOUBLE_BUFFER_EN, tx_start while busy=1 SHALL be ignored; din changes after acceptance SHALL not affect the frame.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, cs=1, dac_sclk=1, sdata=0, busy=0, tx_done_tick=0, and clear all counters, the shift register and the holding register.
REQ-026 Reset mid-frame SHALL abort the frame without a tx_done_tick; the first frame after release SHALL be complete and correct.

Configuration
REQ-027 Macro TX_DOUBLE_BUFFER_EN, when defined, SHALL add a DATA_W holding register plus flag hold_full; tx_start while busy sets hold_full and stores din, and a later start before consumption overwrites it.
REQ-028 With TX_DOUBLE_BUFFER_EN, DONE with hold_full=1 SHALL go directly to SETUP, loading {CTRL, held word}, and clear hold_full; cs is high for exactly one cycle between frames.
REQ-029 Without TX_DOUBLE_BUFFER_EN, no holding register SHALL exist and behaviour SHALL follow REQ-024.

Verification
REQ-030 DIV=1, din=12'hA5C, one tx_start -> 16 bits captured on dac_sclk falls = 16'h0A5C; cs low 32 cycles; tx_done_tick exactly one cycle; busy low the next cycle.
REQ-031 DIV=2, din=12'hFFF then 12'h000 back-to-back starts (second while busy), macro off -> one frame 16'h0FFF, second start ignored, one tx_done_tick.
REQ-032 Macro on, DIV=1, starts with 12'h123 then 12'h456 during the first frame -> frames 16'h0123 and 16'h0456; cs high exactly one cycle between; two tx_done_ticks.
REQ-033 rst pulled low during bit 7 of a frame -> cs=1, dac_sclk=1 immediately, no tx_done_tick; next start with 12'h800 sends 16'h0800 correctly.
REQ-034 tx_start held high continuously, macro off, DIV=1 -> consecutive frames separated by DONE plus one IDLE cycle; every frame is 16 bits.

Source files
------------

// File: rtl/transmit_dac.sv
// -----------------------------------------------------------------------------
// transmit_dac -- serial transmitter for an SPI-style DAC.
//
// Sends one FRAME_W = CTRL_W + DATA_W bit frame ({CTRL, din}) MSB first.
// cs is pulled low for the whole frame. dac_sclk idles high, and the DAC
// samples sdata on the falling edges of dac_sclk. sdata changes only on the
// rising edges, so it is stable for DIV cycles either side of every fall.
//
// Frame timing in sclk cycles, with cs low for 32*DIV cycles by default:
//   SETUP  : DIV cycles, dac_sclk high, first bit on sdata
//   SHIFT  : FRAME_W low phases and FRAME_W-1 high phases, DIV cycles each
//   DONE   : 1 cycle, cs high, tx_done_tick high
//
// Parameters:
//   DATA_W  data word width
//   CTRL_W  control prefix width
//   CTRL    control prefix sent ahead of the data
//   DIV     sclk cycles per dac_sclk half-period (1..255)
//
// Ports:
//   sclk          system clock; all state changes on its rising edge
//   rst           asynchronous reset, active low
//   tx_start      request to send din
//   din           word to transmit, captured when tx_start is accepted
//   dac_sclk      serial clock to the DAC, idle high
//   sdata         serial data, MSB first
//   cs            chip select / sync, active low
//   busy          high while a frame is in progress (SETUP/SHIFT/DONE)
//   tx_done_tick  one-cycle pulse in the DONE cycle
//
// Optional feature: define TX_DOUBLE_BUFFER_EN to add a one-word holding
// register. A start that arrives while busy is then queued, and it goes out
// straight after the current frame with cs high for one cycle only. A newer
// start that arrives before the queued word is sent overwrites that word.
// -----------------------------------------------------------------------------
module transmit_dac #(
  parameter int unsigned              DATA_W = 12,
  parameter int unsigned              CTRL_W = 4,
  parameter logic [CTRL_W-1:0]        CTRL   = 4'b0000,
  parameter int unsigned              DIV    = 2
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] din,
  output logic              dac_sclk,
  output logic              sdata,
  output logic              cs,
  output logic              busy,
  output logic              tx_done_tick
);

  localparam int unsigned FRAME_W = CTRL_W + DATA_W;
  localparam int unsigned BCNT_W  = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [BCNT_W-1:0]   bcnt_q,  bcnt_d;   // falls completed in this frame
  logic [7:0]          hcnt_q,  hcnt_d;   // cycles spent in the current half-period
  logic                phase_q, phase_d;  // in SHIFT: 0 = dac_sclk low, 1 = high

  logic                hcnt_last;
  logic                load;
  logic [DATA_W-1:0]   load_word;

  assign hcnt_last = (hcnt_q == 8'(DIV - 1));

`ifdef TX_DOUBLE_BUFFER_EN
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
`endif

  always_comb begin
    // NOTE: every signal this block drives gets a default first. A path that
    // leaves one of them unassigned would infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    bcnt_d    = bcnt_q;
    hcnt_d    = hcnt_q;
    phase_d   = phase_q;
    load      = 1'b0;
    load_word = din;
`ifdef TX_DOUBLE_BUFFER_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef TX_DOUBLE_BUFFER_EN
        if (hold_full_q) begin
          load        = 1'b1;
          load_word   = hold_q;
          hold_full_d = 1'b0;
          state_d     = SETUP;
        end else
`endif
        if (tx_start) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (hcnt_last) state_d = SHIFT;
        else           hcnt_d  = hcnt_q + 8'd1;
      end

      SHIFT: begin
        if (!hcnt_last) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          hcnt_d = '0;
          if (!phase_q) begin
            // End of a low phase. Either the frame is complete, or dac_sclk
            // rises and the next bit is presented.
            if (bcnt_q == BCNT_W'(FRAME_W - 1)) begin
              state_d = DONE;
            end else begin
              bcnt_d  = bcnt_q + 1'b1;
              phase_d = 1'b1;
              shreg_d = shreg_q << 1;
            end
          end else begin
            phase_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
`ifdef TX_DOUBLE_BUFFER_EN
        if (hold_full_q) begin
          load        = 1'b1;
          load_word   = hold_q;
          hold_full_d = 1'b0;
          state_d     = SETUP;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

`ifdef TX_DOUBLE_BUFFER_EN
    // A start that cannot go out now is queued. It is checked after the
    // consume above, so a start in the same cycle as the consume is kept.
    if (tx_start && (state_q != IDLE || hold_full_q)) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
`endif

    if (load) shreg_d = {CTRL, load_word};

    // Both counters and the phase restart on every state entry, so neither
    // counter can carry a stale count into the next state.
    if (state_d != state_q) begin
      bcnt_d  = '0;
      hcnt_d  = '0;
      phase_d = 1'b0;
    end
  end

  // NOTE: the datapath registers (shift register and holding word) are reset
  // as well as the control state. A reset mid-frame then leaves nothing of
  // the aborted frame behind.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      hcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
    end
  end

`ifdef TX_DOUBLE_BUFFER_EN
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

  // The outputs are decoded from registered state, so reset forces them at
  // once without waiting for a clock edge.
  assign busy         = (state_q != IDLE);
  assign cs           = !(state_q == SETUP || state_q == SHIFT);
  assign dac_sclk     = !(state_q == SHIFT && !phase_q);
  assign sdata        = (state_q == SETUP || state_q == SHIFT) ? shreg_q[FRAME_W-1] : 1'b0;
  assign tx_done_tick = (state_q == DONE);

endmodule

// File: tb/tb_transmit_dac.sv
// -----------------------------------------------------------------------------
// tb_transmit_dac -- directed bench for transmit_dac.
// Instance u_d1 is built with DIV=1 and instance u_d2 with DIV=2. Frames are
// rebuilt from sdata sampled on each dac_sclk fall and compared against
// hand-computed words and cs-low lengths.
// -----------------------------------------------------------------------------
module tb_transmit_dac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  start_r;
  logic [11:0] din_r [2];
  wire  [1:0]  dsclk_w, sd_w, cs_w, busy_w, tick_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  transmit_dac #(.DIV(1)) u_d1 (
    .sclk(clk), .rst(rst_n), .tx_start(start_r[0]), .din(din_r[0]),
    .dac_sclk(dsclk_w[0]), .sdata(sd_w[0]), .cs(cs_w[0]),
    .busy(busy_w[0]), .tx_done_tick(tick_w[0])
  );

  transmit_dac #(.DIV(2)) u_d2 (
    .sclk(clk), .rst(rst_n), .tx_start(start_r[1]), .din(din_r[1]),
    .dac_sclk(dsclk_w[1]), .sdata(sd_w[1]), .cs(cs_w[1]),
    .busy(busy_w[1]), .tx_done_tick(tick_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle start request. din is scrambled right after acceptance, which
  // shows whether a later din change leaks into the frame.
  task automatic pulse_start(input int k, input logic [11:0] d);
    start_r[k] = 1'b1;
    din_r[k]   = d;
    @(negedge clk);
    start_r[k] = 1'b0;
    din_r[k]   = ~d;
  endtask

  // Wait (bounded) for cs low, then follow the frame until cs rises again.
  // The task returns on the first negedge with cs high, which is the DONE cycle.
  task automatic capture(input int k, output logic [15:0] word, output int falls,
                         output int cslow, output int unstable, output logic seen);
    logic prev_clk, prev_sd;
    word = '0; falls = 0; cslow = 0; unstable = 0; seen = 1'b0;
    for (int t = 0; t < 200 && cs_w[k]; t++) @(negedge clk);
    if (cs_w[k]) return;
    seen     = 1'b1;
    prev_clk = 1'b1;
    prev_sd  = sd_w[k];
    for (int t = 0; t < 1000 && !cs_w[k]; t++) begin
      cslow++;
      if (prev_clk && !dsclk_w[k]) begin
        word = {word[14:0], sd_w[k]};
        falls++;
      end
      // sdata may only change together with a dac_sclk rise.
      if (sd_w[k] !== prev_sd && !(!prev_clk && dsclk_w[k])) unstable++;
      prev_clk = dsclk_w[k];
      prev_sd  = sd_w[k];
      @(negedge clk);
    end
  endtask

  // Capture one frame and check it. The task returns one cycle after DONE.
  task automatic check_frame(input int k, input string tag, input logic [15:0] exp_word,
                             input int exp_cslow);
    logic [15:0] word;
    int falls, cslow, unstable;
    logic seen;
    capture(k, word, falls, cslow, unstable, seen);
    check({tag, "_started"}, 32'(seen), 32'd1);
    check({tag, "_word"},    32'(word), 32'(exp_word));
    check({tag, "_falls"},   falls,     16);
    check({tag, "_cslow"},   cslow,     exp_cslow);
    check({tag, "_stable"},  unstable,  0);
    check({tag, "_done_cs"}, 32'(cs_w[k]),   32'd1);
    check({tag, "_tick"},    32'(tick_w[k]), 32'd1);
    check({tag, "_busy_done"}, 32'(busy_w[k]), 32'd1);
    @(negedge clk);
    check({tag, "_tick_1cyc"}, 32'(tick_w[k]), 32'd0);
  endtask

  initial begin
    int ticks;
    int lows;

    rst_n    = 1'b0;
    start_r  = '0;
    din_r[0] = '0;
    din_r[1] = '0;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    check("rst_cs",    32'(cs_w),    32'h3);
    check("rst_dsclk", 32'(dsclk_w), 32'h3);
    check("rst_sdata", 32'(sd_w),    32'h0);
    check("rst_busy",  32'(busy_w),  32'h0);
    check("rst_tick",  32'(tick_w),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // DIV=1 single frame: 0x0A5C, with cs low for 32 cycles.
    pulse_start(0, 12'hA5C);
    check_frame(0, "d1_a5c", 16'h0A5C, 32);
    check("d1_a5c_idle_busy", 32'(busy_w[0]), 32'd0);
    check("d1_a5c_idle_cs",   32'(cs_w[0]),   32'd1);

`ifndef TX_DOUBLE_BUFFER_EN
    // DIV=2: a second start while busy is ignored.
    fork
      begin
        pulse_start(1, 12'hFFF);
        repeat (3) @(negedge clk);
        start_r[1] = 1'b1;
        din_r[1]   = 12'h000;
        @(negedge clk);
        start_r[1] = 1'b0;
      end
      check_frame(1, "d2_fff", 16'h0FFF, 64);
    join
    ticks = 0;
    lows  = 0;
    for (int t = 0; t < 150; t++) begin
      if (tick_w[1]) ticks++;
      if (!cs_w[1])  lows++;
      @(negedge clk);
    end
    check("d2_no_second_tick",  ticks, 0);
    check("d2_no_second_frame", lows,  0);
`else
    // DIV=1, double-buffered: the second start is queued and follows with
    // only one cycle of cs high between the frames.
    fork
      begin
        pulse_start(0, 12'h123);
        repeat (5) @(negedge clk);
        pulse_start(0, 12'h456);
      end
      check_frame(0, "db_123", 16'h0123, 32);
    join
    check("db_gap_one_cycle", 32'(cs_w[0]), 32'd0);
    check_frame(0, "db_456", 16'h0456, 32);
    check("db_idle_busy", 32'(busy_w[0]), 32'd0);
`endif

    // Reset during bit 7 aborts the frame without a tick.
    pulse_start(0, 12'h3C3);
    repeat (15) @(negedge clk);
    check("mid_in_bit7_low", 32'(dsclk_w[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cs",    32'(cs_w[0]),    32'd1);
    check("mid_rst_dsclk", 32'(dsclk_w[0]), 32'd1);
    check("mid_rst_sdata", 32'(sd_w[0]),    32'd0);
    check("mid_rst_busy",  32'(busy_w[0]),  32'd0);
    ticks = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (tick_w[0]) ticks++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (tick_w[0]) ticks++;
    check("mid_rst_no_tick", ticks, 0);
    pulse_start(0, 12'h800);
    check_frame(0, "after_rst_800", 16'h0800, 32);

`ifndef TX_DOUBLE_BUFFER_EN
    // tx_start held high: DONE, then one IDLE cycle, then the next frame.
    start_r[0] = 1'b1;
    din_r[0]   = 12'h5A1;
    @(negedge clk);
    check_frame(0, "hold_f1", 16'h05A1, 32);
    check("hold_idle_cs",   32'(cs_w[0]),   32'd1);
    check("hold_idle_busy", 32'(busy_w[0]), 32'd0);
    din_r[0] = 12'h0F0;
    @(negedge clk);
    check("hold_restart_cs", 32'(cs_w[0]), 32'd0);
    check_frame(0, "hold_f2", 16'h00F0, 32);
    start_r[0] = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
